// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, NOP encoding, default reset vector,
// fetch FSM states and the IF/ID update operations.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer: BOOT spends exactly one cycle after reset, then RUN forever.
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // What the IF/ID pipeline register does on the next edge.
  typedef enum logic [1:0] {
    IFID_BUBBLE = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

  // Word-align an address by clearing the two byte-offset bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selector: branch > jump > stall-hold > PC+4.
// Redirect targets are word-aligned; PC+4 wraps modulo 2^32.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  // Priority mux: the older (EX) branch beats the younger (ID) jump, and any
  // redirect beats a stall.
  always_comb begin
    next_pc = pc_plus4;
    if (branch_taken) begin
      next_pc = align_word(branch_target);
    end else if (jump) begin
      next_pc = align_word(jump_target);
    end else if (stall) begin
      next_pc = pc;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencer and IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch_count port and a
// counter of valid IF/ID loads.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count
`endif
);

  fetch_state_e    state_r;
  fetch_state_e    state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] sel_next_pc_s;
  logic [XLEN-1:0] pc_plus4_s;
  ifid_op_e        ifid_op_s;
  logic [XLEN-1:0] ifid_pc4_r;
  logic [XLEN-1:0] ifid_instr_r;
  logic            ifid_valid_r;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_r),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_plus4      (pc_plus4_s),
    .next_pc       (sel_next_pc_s)
  );

  // FSM state register; reset always returns to BOOT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: BOOT lasts one cycle, RUN holds until reset.
  always_comb begin
    state_next_s = BOOT;
    case (state_r)
      BOOT:    state_next_s = RUN;
      RUN:     state_next_s = RUN;
      default: state_next_s = BOOT;
    endcase
  end

  // FSM outputs: PC update and IF/ID operation. BOOT keeps the PC on the
  // reset vector and inserts a bubble so the first real fetch is not lost.
  always_comb begin
    pc_next_s = pc_r;
    ifid_op_s = IFID_BUBBLE;
    case (state_r)
      BOOT: begin
        pc_next_s = pc_r;
        ifid_op_s = IFID_BUBBLE;
      end
      RUN: begin
        pc_next_s = sel_next_pc_s;
        if (flush || branch_taken || jump) begin
          ifid_op_s = IFID_BUBBLE;
        end else if (stall) begin
          ifid_op_s = IFID_HOLD;
        end else begin
          ifid_op_s = IFID_LOAD;
        end
      end
      default: begin
        pc_next_s = pc_r;
        ifid_op_s = IFID_BUBBLE;
      end
    endcase
  end

  // PC register; imem_addr is a direct view of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_instr_r <= NOP_INSTR;
      ifid_valid_r <= 1'b0;
    end else begin
      case (ifid_op_s)
        IFID_LOAD: begin
          ifid_pc4_r   <= pc_plus4_s;
          ifid_instr_r <= imem_rdata;
          ifid_valid_r <= 1'b1;
        end
        IFID_HOLD: begin
          ifid_pc4_r   <= ifid_pc4_r;
          ifid_instr_r <= ifid_instr_r;
          ifid_valid_r <= ifid_valid_r;
        end
        default: begin
          ifid_pc4_r   <= 32'h0000_0000;
          ifid_instr_r <= NOP_INSTR;
          ifid_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_count_r;

  // Counts every edge that loads a valid instruction; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_r <= 32'h0000_0000;
    end else if (ifid_op_s == IFID_LOAD) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign fetch_count = fetch_count_r;
`endif

  assign imem_addr  = pc_r;
  assign ifid_pc4   = ifid_pc4_r;
  assign ifid_instr = ifid_instr_r;
  assign ifid_valid = ifid_valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Instruction memory returns a
// word derived from its address so each IF/ID load can be traced to its PC.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int total;
  int bad;

  logic [96:0] obs;
  logic [96:0] exp_v;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_pc4      (ifid_pc4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  assign imem_rdata = instr_at(imem_addr);
  assign obs = {imem_addr, ifid_pc4, ifid_instr, ifid_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    jump          = 1'b0;
    jump_target   = 32'h0000_0000;
  endtask

  // Reset with every other input active must still give PC=0 and a bubble.
  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_0500;
    jump = 1'b1; jump_target = 32'h0000_0600;
    tick(); tick();
    exp_v = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset got=%h want=%h", obs, exp_v); end
    clear_inputs();
  endtask

  // Free run out of reset: BOOT bubble, then consecutive words.
  task automatic test_sequential();
    rst_n = 1'b1;
    tick();
    exp_v = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL seq_boot got=%h want=%h", obs, exp_v); end
    for (int i = 1; i <= 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      tick();
      exp_v = {a, a, instr_at(a - 32'd4), 1'b1};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL seq_%0d got=%h want=%h", i, obs, exp_v); end
    end
  endtask

  // Two stall cycles at PC=0x10 hold PC and IF/ID, then fetch resumes.
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {32'h0000_0010, 32'h0000_0010, instr_at(32'h0000_000C), 1'b1};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stall_%0d got=%h want=%h", i, obs, exp_v); end
    end
    stall = 1'b0;
    tick();
    exp_v = {32'h0000_0014, 32'h0000_0014, instr_at(32'h0000_0010), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL stall_resume got=%h want=%h", obs, exp_v); end
  endtask

  // Branch beats jump beats stall; targets are word-aligned.
  task automatic test_redirect();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103;
    jump = 1'b1; jump_target = 32'h0000_0200;
    tick();
    exp_v = {32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redir_branch got=%h want=%h", obs, exp_v); end
    branch_taken = 1'b0; jump_target = 32'h0000_020A;
    tick();
    exp_v = {32'h0000_0208, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redir_jump got=%h want=%h", obs, exp_v); end
    clear_inputs();
    tick();
    exp_v = {32'h0000_020C, 32'h0000_020C, instr_at(32'h0000_0208), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redir_after got=%h want=%h", obs, exp_v); end
  endtask

  // PC+4 wraps from the top of the address space to zero.
  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    exp_v = {32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_top got=%h want=%h", obs, exp_v); end
    clear_inputs();
    tick();
    exp_v = {32'h0000_0000, 32'h0000_0000, instr_at(32'hFFFF_FFFC), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_zero got=%h want=%h", obs, exp_v); end
    tick();
    exp_v = {32'h0000_0004, 32'h0000_0004, instr_at(32'h0000_0000), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_next got=%h want=%h", obs, exp_v); end
  endtask

  // Flush with stall keeps PC but bubbles IF/ID; flush alone advances PC.
  task automatic test_flush();
    branch_taken = 1'b1; branch_target = 32'h0000_001C;
    tick();
    clear_inputs();
    tick();
    exp_v = {32'h0000_0020, 32'h0000_0020, instr_at(32'h0000_001C), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush_setup got=%h want=%h", obs, exp_v); end
    flush = 1'b1; stall = 1'b1;
    tick();
    exp_v = {32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush_stall got=%h want=%h", obs, exp_v); end
    stall = 1'b0;
    tick();
    exp_v = {32'h0000_0024, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush_only got=%h want=%h", obs, exp_v); end
    clear_inputs();
    tick();
    exp_v = {32'h0000_0028, 32'h0000_0028, instr_at(32'h0000_0024), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush_resume got=%h want=%h", obs, exp_v); end
  endtask

  // Reset during a branch wins; the following BOOT cycle ignores redirects.
  task automatic test_reset_mid_branch();
    rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
    tick();
    exp_v = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL rst_branch got=%h want=%h", obs, exp_v); end
    rst_n = 1'b1;
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL boot_ignores got=%h want=%h", obs, exp_v); end
    clear_inputs();
    tick();
    exp_v = {32'h0000_0004, 32'h0000_0004, instr_at(32'h0000_0000), 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL boot_first got=%h want=%h", obs, exp_v); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  // Five valid loads, one stall, one flush: count is 5, reset clears it.
  task automatic test_perf_count();
    rst_n = 1'b0;
    tick();
    total++;
    if (fetch_count !== 32'd0) begin bad++; $display("FAIL perf_rst got=%0d want=0", fetch_count); end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b1;
    tick();
    clear_inputs();
    total++;
    if (fetch_count !== 32'd5) begin bad++; $display("FAIL perf_cnt got=%0d want=5", fetch_count); end
    rst_n = 1'b0;
    tick();
    total++;
    if (fetch_count !== 32'd0) begin bad++; $display("FAIL perf_clr got=%0d want=0", fetch_count); end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_flush();
    test_reset_mid_branch();
`ifdef FETCH_PERF_CNT_EN
    test_perf_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
